// File: rtl/spi_cmd_master_pkg.sv
// spi_cmd_master_pkg: shared FSM state encoding, gap limit, standard frame lengths and counter width helper
package spi_cmd_master_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    localparam int CS_GAP_MIN     = 1;
    localparam int VEC_FRAME_BITS = 74;

    // counter width for a modulus n, never narrower than one bit
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_cmd_master_sclk_div.sv
// spi_sclk_div: DIV-cycle down counter giving a one-cycle phase-toggle tick
//   clk, reset_n : clock, synchronous active-low reset
//   load         : reload to DIV-1 at frame start
//   en           : count while the frame is on the bus
//   tick         : counter at zero while enabled; it reloads itself on that cycle
module spi_sclk_div import spi_cmd_master_pkg::*; #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int            CW  = cnt_w(DIV);
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = en && div_cnt == '0;

    always_ff @(posedge clk) begin
        if (!reset_n)
            div_cnt <= '0;
        else if (load || tick)
            div_cnt <= TOP;
        else if (en)
            div_cnt <= div_cnt - 1'b1;
    end
endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 master sending one MSB-first frame per valid/ready handshake
//   clk, reset_n     : clock, synchronous active-low reset
//   i_valid/o_ready  : command handshake, ready only in IDLE
//   i_len, i_data    : frame length (clamped to MAX_BITS) and payload, bit len-1 sent first
//   o_csb/o_sclk/o_mosi : SPI bus, CPOL=0 CPHA=0
//   o_busy           : ~o_ready
//   o_done           : one-cycle pulse on the first cycle with csb high after a frame
module spi_cmd_master import spi_cmd_master_pkg::*; #(
    parameter int MAX_BITS = 80,
    parameter int DIV      = 2,
    parameter int CS_GAP   = 2,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [MAX_BITS-1:0] i_data,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_busy,
    output logic                o_done
);
    localparam int               GW      = cnt_w(CS_GAP);
    localparam logic [GW-1:0]    GAP_TOP = GW'(CS_GAP - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    state_t              state;
    logic [MAX_BITS-1:0] sh, aligned;
    logic [LEN_W-1:0]    len_eff, bit_cnt;
    logic [GW-1:0]       gap_cnt;
    logic                tick, start;

    assign len_eff = i_len > MAX_LEN ? MAX_LEN : i_len;
    // left-justify the payload so the first bit to send is always the register MSB
    assign aligned = i_data << (MAX_LEN - len_eff);
    assign start   = i_valid && state == IDLE && len_eff != '0;
    assign o_ready = state == IDLE;
    assign o_busy  = ~o_ready;

    spi_sclk_div #(.DIV(DIV)) u_div (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (start),
        .en     (state == SHIFT_LO || state == SHIFT_HI || state == HOLD),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            o_csb   <= 1'b1;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b0;
            o_done  <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sh      <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_valid) begin
                    if (len_eff == '0) begin
                        o_done  <= 1'b1;
                        gap_cnt <= GAP_TOP;
                        state   <= GAP;
                    end else begin
                        o_csb   <= 1'b0;
                        o_sclk  <= 1'b0;
                        o_mosi  <= aligned[MAX_BITS-1];
                        sh      <= aligned << 1;
                        bit_cnt <= len_eff - 1'b1;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: if (tick) begin
                    o_sclk <= 1'b1;
                    state  <= SHIFT_HI;
                end
                SHIFT_HI: if (tick) begin
                    o_sclk <= 1'b0;
                    if (bit_cnt == '0)
                        state <= HOLD;
                    else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        o_mosi  <= sh[MAX_BITS-1];
                        sh      <= sh << 1;
                        state   <= SHIFT_LO;
                    end
                end
                HOLD: if (tick) begin
                    o_csb   <= 1'b1;
                    o_mosi  <= 1'b0;
                    o_done  <= 1'b1;
                    gap_cnt <= GAP_TOP;
                    state   <= GAP;
                end
                GAP: if (gap_cnt == '0) state <= IDLE;
                     else gap_cnt <= gap_cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
